// File: rtl/hamming_link_ctrl.sv
// hamming_link_ctrl
//   Controller that runs one 4-bit word at a time through an external
//   Hamming(7,4) encode -> fault-injection -> decode chain. It launches
//   the word and the injection position, waits the chain latency LAT,
//   then captures the decoder outputs and checks them against the
//   launched word. The decoder should report a syndrome equal to the
//   injected bit position and return the original data.
//   Optional feature macro: HAMMING_LINK_STATS_EN (saturating link
//   statistics counters). When it is undefined, stat_* are tied to 0.
module hamming_link_ctrl #(
    parameter int unsigned LAT = 3  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active low
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
    input  logic [1:0]  inj_mode,
    input  logic [2:0]  inj_fixed_pos,
    output logic [3:0]  enc_data,
    output logic [2:0]  inj_pos,
    input  logic [2:0]  dec_syndrome,
    input  logic [3:0]  dec_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_data,
    output logic [2:0]  out_syndrome,
    output logic        out_corrected,
    output logic        out_mismatch,
    output logic [15:0] stat_words,
    output logic [15:0] stat_corr,
    output logic [15:0] stat_fail
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    // True when the decoder result disagrees with what was launched:
    // data must be restored and the syndrome must name the flipped bit.
    function automatic logic link_mismatch(input logic [3:0] got_data,
                                           input logic [3:0] exp_data,
                                           input logic [2:0] got_syn,
                                           input logic [2:0] exp_syn);
        link_mismatch = (got_data != exp_data) || (got_syn != exp_syn);
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  rot_q, rot_d;
    logic [3:0]  enc_data_q, enc_data_d;
    logic [3:0]  exp_data_q, exp_data_d;
    logic [2:0]  inj_pos_q, inj_pos_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_data_q, out_data_d;
    logic [2:0]  out_syn_q, out_syn_d;
    logic        out_corr_q, out_corr_d;
    logic        out_mis_q, out_mis_d;
    logic        hs_s;

    assign in_ready = (state_q == ST_IDLE);
    assign hs_s     = (state_q == ST_RESULT) && out_ready;

    // Next-state and datapath updates for the three-state transaction FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rot_d       = rot_q;
        enc_data_d  = enc_data_q;
        exp_data_d  = exp_data_q;
        inj_pos_d   = inj_pos_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_corr_d  = out_corr_q;
        out_mis_d   = out_mis_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_WAIT;
                    enc_data_d = in_data;
                    exp_data_d = in_data;
                    cnt_d      = LAT_M1;
                    case (inj_mode)
                        2'b01: inj_pos_d = inj_fixed_pos;
                        2'b10: begin
                            inj_pos_d = rot_q;
                            rot_d     = (rot_q == 3'd7) ? 3'd1 : rot_q + 3'd1;
                        end
                        default: inj_pos_d = 3'd0;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESULT;
                    out_valid_d = 1'b1;
                    out_data_d  = dec_data;
                    out_syn_d   = dec_syndrome;
                    out_corr_d  = (dec_syndrome != 3'd0);
                    out_mis_d   = link_mismatch(dec_data, exp_data_q,
                                                dec_syndrome, inj_pos_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    inj_pos_d   = 3'd0;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                inj_pos_d   = 3'd0;
            end
        endcase
    end

    // State and datapath registers; reset drops any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rot_q       <= 3'd1;
            enc_data_q  <= 4'd0;
            exp_data_q  <= 4'd0;
            inj_pos_q   <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 4'd0;
            out_syn_q   <= 3'd0;
            out_corr_q  <= 1'b0;
            out_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rot_q       <= rot_d;
            enc_data_q  <= enc_data_d;
            exp_data_q  <= exp_data_d;
            inj_pos_q   <= inj_pos_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            out_corr_q  <= out_corr_d;
            out_mis_q   <= out_mis_d;
        end
    end

    assign enc_data      = enc_data_q;
    assign inj_pos       = inj_pos_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_syndrome  = out_syn_q;
    assign out_corrected = out_corr_q;
    assign out_mismatch  = out_mis_q;

`ifdef HAMMING_LINK_STATS_EN
    // Saturating increment so counters stick at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] words_q, words_d;
    logic [15:0] corr_q, corr_d;
    logic [15:0] fail_q, fail_d;

    // Count each completed result handshake and its flags.
    always_comb begin
        words_d = words_q;
        corr_d  = corr_q;
        fail_d  = fail_q;
        if (hs_s) begin
            words_d = sat_inc(words_q);
            corr_d  = out_corr_q ? sat_inc(corr_q) : corr_q;
            fail_d  = out_mis_q  ? sat_inc(fail_q) : fail_q;
        end else begin
            words_d = words_q;
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_q <= 16'd0;
            corr_q  <= 16'd0;
            fail_q  <= 16'd0;
        end else begin
            words_q <= words_d;
            corr_q  <= corr_d;
            fail_q  <= fail_d;
        end
    end

    assign stat_words = words_q;
    assign stat_corr  = corr_q;
    assign stat_fail  = fail_q;
`else
    logic unused_hs_s;
    assign unused_hs_s = hs_s;
    assign stat_words  = 16'd0;
    assign stat_corr   = 16'd0;
    assign stat_fail   = 16'd0;
`endif

endmodule

// File: tb/tb_hamming_link_ctrl.sv
// Self-checking bench for hamming_link_ctrl. A behavioural Hamming(7,4)
// channel (encode, flip, decode, LAT-cycle delay) closes the loop, and
// expected results come from the link rules: data restored, syndrome
// equal to the launched position, rotation 1..7 on rotate-mode accepts.
module tb_hamming_link_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = 4'd0;
    logic [1:0]  inj_mode = 2'd0;
    logic [2:0]  inj_fixed_pos = 3'd0;
    logic [3:0]  enc_data;
    logic [2:0]  inj_pos;
    logic [2:0]  dec_syndrome;
    logic [3:0]  dec_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_data;
    logic [2:0]  out_syndrome;
    logic        out_corrected;
    logic        out_mismatch;
    logic [15:0] stat_words, stat_corr, stat_fail;

    int compared = 0;
    int mismatched = 0;
    int rot_ptr = 1;
    int m_words = 0, m_corr = 0, m_fail = 0;
    logic force_zero = 1'b0;

    hamming_link_ctrl #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inj_mode(inj_mode), .inj_fixed_pos(inj_fixed_pos),
        .enc_data(enc_data), .inj_pos(inj_pos),
        .dec_syndrome(dec_syndrome), .dec_data(dec_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome),
        .out_corrected(out_corrected), .out_mismatch(out_mismatch),
        .stat_words(stat_words), .stat_corr(stat_corr), .stat_fail(stat_fail)
    );

    always #5 clk = ~clk;

    // ---------------- channel model (environment) ----------------
    function automatic logic [7:1] enc7(input logic [3:0] d);
        logic [7:1] cw;
        cw[3] = d[0]; cw[5] = d[1]; cw[6] = d[2]; cw[7] = d[3];
        cw[1] = cw[3] ^ cw[5] ^ cw[7];
        cw[2] = cw[3] ^ cw[6] ^ cw[7];
        cw[4] = cw[5] ^ cw[6] ^ cw[7];
        return cw;
    endfunction

    logic [6:0] chan_s;  // {syndrome, data}
    always_comb begin
        logic [7:1] cw;
        logic [2:0] s;
        cw = enc7(enc_data);
        if (inj_pos != 3'd0) cw[inj_pos] = ~cw[inj_pos];
        s = 3'd0;
        for (int p = 1; p <= 7; p++) if (cw[p]) s = s ^ 3'(p);
        if (s != 3'd0) cw[s] = ~cw[s];
        chan_s = {s, force_zero ? 4'd0 : {cw[7], cw[6], cw[5], cw[3]}};
    end

    // LAT-1 register stages: result visible in time for the edge T+LAT.
    logic [6:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= chan_s;
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign dec_syndrome = pipe[LAT-2][6:4];
    assign dec_data     = pipe[LAT-2][3:0];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef HAMMING_LINK_STATS_EN
        check("stat_words", stat_words, 16'(m_words));
        check("stat_corr",  stat_corr,  16'(m_corr));
        check("stat_fail",  stat_fail,  16'(m_fail));
`else
        check("stat_words_tied", stat_words, 16'd0);
        check("stat_corr_tied",  stat_corr,  16'd0);
        check("stat_fail_tied",  stat_fail,  16'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and follow it through to the result handshake.
    task automatic send_word(input logic [3:0] data, input logic [1:0] mode,
                             input logic [2:0] fpos, input int hold);
        int k;
        int exp_pos;
        logic exp_mis;
        logic [3:0] exp_data;
        logic [3:0] s_data; logic [2:0] s_syn; logic s_corr, s_mis;
        k = 0;
        while (!in_ready && k < 50) begin tick(); k++; end
        check("in_ready_before_accept", {15'd0, in_ready}, 16'd1);
        case (mode)
            2'b01: exp_pos = int'(fpos);
            2'b10: begin exp_pos = rot_ptr; rot_ptr = (rot_ptr == 7) ? 1 : rot_ptr + 1; end
            default: exp_pos = 0;
        endcase
        exp_data = force_zero ? 4'd0 : data;
        exp_mis  = (exp_data != data);
        in_valid = 1'b1; in_data = data; inj_mode = mode; inj_fixed_pos = fpos;
        out_ready = (hold == 0);
        tick();  // accept edge T
        in_valid = 1'b0;
        inj_mode = 2'($urandom_range(0, 3));   // must not affect word in flight
        inj_fixed_pos = 3'($urandom_range(0, 7));
        check("enc_data_at_T", {12'd0, enc_data}, {12'd0, data});
        check("inj_pos_wait", {13'd0, inj_pos}, 16'(exp_pos));
        check("in_ready_wait", {15'd0, in_ready}, 16'd0);
        k = 0;
        while (k < 20) begin
            tick(); k++;
            if (out_valid) break;
        end
        check("out_valid_latency", 16'(k), 16'(LAT));
        check("out_data", {12'd0, out_data}, {12'd0, exp_data});
        check("out_syndrome", {13'd0, out_syndrome}, 16'(exp_pos));
        check("out_corrected", {15'd0, out_corrected}, {15'd0, exp_pos != 0});
        check("out_mismatch", {15'd0, out_mismatch}, {15'd0, exp_mis});
        s_data = out_data; s_syn = out_syndrome; s_corr = out_corrected; s_mis = out_mismatch;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_data = ~data;
            tick();
            check("hold_valid", {15'd0, out_valid}, 16'd1);
            check("hold_stable", {4'd0, out_data, out_syndrome, out_corrected, out_mismatch, 3'd0},
                  {4'd0, s_data, s_syn, s_corr, s_mis, 3'd0});
            check("hold_in_ready", {15'd0, in_ready}, 16'd0);
            check("hold_enc_data", {12'd0, enc_data}, {12'd0, data});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();  // handshake edge
        if (m_words < 65535) m_words++;
        if (exp_pos != 0 && m_corr < 65535) m_corr++;
        if (exp_mis && m_fail < 65535) m_fail++;
        check("idle_in_ready", {15'd0, in_ready}, 16'd1);
        check("idle_out_valid", {15'd0, out_valid}, 16'd0);
        check("idle_inj_pos", {13'd0, inj_pos}, 16'd0);
        check("idle_enc_hold", {12'd0, enc_data}, {12'd0, data});
        check_stats();
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_enc_data", {12'd0, enc_data}, 16'd0);
        check("rst_inj_pos", {13'd0, inj_pos}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_bits", {8'd0, out_data, out_syndrome, out_corrected},
              16'd0);
        check("rst_out_mismatch", {15'd0, out_mismatch}, 16'd0);
        check_stats();
    endtask

    initial begin
        // Reset
        #12;
        check_reset_values();
        rst = 1'b1;
        tick();

        // Mode off, word 1011
        send_word(4'b1011, 2'b00, 3'd0, 0);
        // Fixed mode, position 5, word 0110
        send_word(4'b0110, 2'b01, 3'd5, 0);
        // Fixed mode with position 0 means no injection
        send_word(4'b1001, 2'b01, 3'd0, 0);
        // Reserved mode behaves as off
        send_word(4'b0101, 2'b11, 3'd3, 0);
        // Rotate mode, 8 consecutive words (1..7,1)
        for (int i = 0; i < 8; i++) send_word(4'($urandom_range(0, 15)), 2'b10, 3'd0, 0);
        // Forced decoder failure on word 1111
        force_zero = 1'b1;
        send_word(4'b1111, 2'b00, 3'd0, 0);
        force_zero = 1'b0;
        // Back-pressure: out_ready low 5 cycles
        send_word(4'b0011, 2'b01, 3'd7, 5);

        // Randomised traffic
        for (int i = 0; i < 30; i++)
            send_word(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        // Reset pulse during WAIT
        in_valid = 1'b1; in_data = 4'b1100; inj_mode = 2'b10;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        rot_ptr = 1; m_words = 0; m_corr = 0; m_fail = 0;
        check_reset_values();
        #2 rst = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            check("no_result_after_reset", {15'd0, out_valid}, 16'd0);
        end
        send_word(4'b1010, 2'b10, 3'd0, 0);
        send_word(4'b0001, 2'b10, 3'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hamming_link_ctrl.md
# hamming_link_ctrl

Transaction controller that sequences 4-bit data words through the Hamming(7,4) encode -> fault-injection -> decode chain, one word in flight at a time. It accepts words on a valid/ready input, drives the encoder data and the fault-injection control, and waits the chain's fixed latency. It then samples syndrome and decoded data, checks them against the launched word and expected syndrome, and presents the result on a valid/ready output. Optional counters accumulate link statistics.

## Interface
- LAT, 3: cycles from an `enc_data`/`inj_pos` update to valid `dec_syndrome`/`dec_data`; legal range 1..15.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  word offered.
- in_ready  output  1  controller can accept; high only in IDLE.
- in_data  input  4  data word.
- inj_mode  input  2  fault schedule: 00 off, 01 fixed, 10 rotate, 11 reserved (treated as off).
- inj_fixed_pos  input  3  bit position (1..7) for fixed mode; 0 means no injection.
- enc_data  output  4  data to encoder.
- inj_pos  output  3  bit position to flip in the codeword; 0 means no flip.
- dec_syndrome  input  3  syndrome from decoder.
- dec_data  input  4  corrected data from decoder.
- out_valid  output  1  result available.
- out_ready  input  1  result consumer ready.
- out_data  output  4  sampled `dec_data`.
- out_syndrome  output  3  sampled `dec_syndrome`.
- out_corrected  output  1  sampled syndrome is non-zero.
- out_mismatch  output  1  `out_data` differs from the launched word, or the syndrome differs from the launched `inj_pos`.
- stat_words, stat_corr, stat_fail  output  16 each  statistics counters (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESULT.
- IDLE -> WAIT on `in_valid & in_ready`. On that edge, register `enc_data <= in_data`, store the word as expected data, and register `inj_pos` from the schedule.
- Rotate mode: `inj_pos` takes the rotation pointer, then the pointer advances 1,2,...,7,1. The pointer is a wrap-around counter that only advances on accepts made in rotate mode.
- Fixed mode: `inj_pos = inj_fixed_pos`.
- Off/reserved modes: `inj_pos = 0`.
- `inj_mode` is sampled only at accept; a change during WAIT/RESULT has no effect on the word in flight.
- WAIT: a down-counter is loaded with LAT-1 at accept. When it reaches 0, the next edge samples `dec_*` into the `out_*` registers and computes the flags, then goes to RESULT.
- Expected syndrome equals the launched `inj_pos`: 0 for no injection, p for a single flip at position p.
- RESULT: `out_valid` is high and the outputs are stable. On `out_valid & out_ready` the FSM returns to IDLE.
- `enc_data` holds its last value in IDLE. `inj_pos` is driven 0 on return to IDLE.
- No pipelining: `in_ready` stays low until the result handshake completes.

## Timing
- Accept at edge T. `enc_data`/`inj_pos` are valid from T. `dec_*` is sampled at edge T+LAT. `out_valid` is high from T+LAT onward.
- If `out_ready` is high when `out_valid` rises, the FSM is in IDLE after edge T+LAT+1. The next accept is possible at edge T+LAT+2, so peak throughput is one word per LAT+2 cycles.
- `out_*` must not change while `out_valid` is high and `out_ready` is low.
- `in_ready` is combinational from state (state==IDLE). `out_valid` is registered.
- Reset values: `in_ready` 1 (IDLE), `enc_data` 0, `inj_pos` 0, `out_valid` 0, `out_data` 0, `out_syndrome` 0, `out_corrected` 0, `out_mismatch` 0, rotation pointer 1, counters 0.
- Reset asserted mid-WAIT or mid-RESULT: the word is dropped, no result is produced, and the FSM is in IDLE immediately.

## Configuration
- `HAMMING_LINK_STATS_EN` defined: on each result handshake, `stat_words` increments. `stat_corr` increments if `out_corrected`, and `stat_fail` increments if `out_mismatch`. All three counters saturate at 0xFFFF and clear only on reset.
- Macro undefined: counter logic is omitted and all three `stat_*` outputs are tied to 0.

## Test plan
- Mode off, LAT=3, `in_data`=1011 accepted at T, `out_ready`=1 -> `enc_data`=1011 at T; `out_valid` at T+3 with `out_data`=1011, `out_syndrome`=000, `out_corrected`=0, `out_mismatch`=0; `in_ready` high again at T+4.
- Fixed mode, `inj_fixed_pos`=5, word 0110 -> `inj_pos`=5 during WAIT; result `out_data`=0110, `out_syndrome`=101, `out_corrected`=1, `out_mismatch`=0; `inj_pos`=0 after return to IDLE.
- Rotate mode, 8 consecutive words -> `inj_pos` sequence 1,2,3,4,5,6,7,1; every result has `out_mismatch`=0 and `out_syndrome` equal to its `inj_pos`.
- Decoder model forced to return 0000 for launched word 1111 -> `out_mismatch`=1. With the macro defined, `stat_fail`=1 and `stat_words`=1 after the handshake.
- `out_ready` held low 5 cycles after `out_valid` rises -> `out_*` stable, `in_ready`=0 and `in_valid` ignored throughout; the word is accepted only after the handshake.
- `rst` pulsed low during WAIT -> `out_valid` never asserts for that word; all outputs at reset values; the next word completes normally, with rotate mode restarting at position 1.
